// File: rtl/split_sweep_checker_pkg.sv
// Shared types and default constants for the range-sweeping constraint checker.
// Imported by the interface, the constraint evaluator and the top.
package split_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int          DEF_A_W   = 13;
    localparam int          DEF_B_W   = 14;
    localparam int          DEF_ACC_W = 16;
    localparam logic [15:0] DEF_SUB_K = 16'h39dd;
    localparam logic [15:0] DEF_ADD_K = 16'he8c3;
    localparam int          DEF_SHIFT = 1;
    localparam int          DEF_CNT_W = 16;

    // Bit positions inside cfg_en
    localparam int EN_C1 = 0;
    localparam int EN_C2 = 1;
    localparam int EN_C3 = 2;

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/split_sweep_checker_if.sv
// Solution stream carrying each satisfying (A, B) pair under valid/ready.
// The checker drives it through the master modport.
interface split_sweep_checker_if
    import split_sweep_pkg::*;
#(
    parameter int A_W = DEF_A_W,
    parameter int B_W = DEF_B_W
);
    logic           sol_valid;
    logic           sol_ready;
    logic [A_W-1:0] sol_a;
    logic [B_W-1:0] sol_b;

    modport master (
        output sol_valid,
        output sol_a,
        output sol_b,
        input  sol_ready
    );

    modport slave (
        input  sol_valid,
        input  sol_a,
        input  sol_b,
        output sol_ready
    );
endinterface

// File: rtl/split_sweep_checker_constraint_eval.sv
// Combinational evaluation of the three constraints on one (a, b) candidate.
// A disabled constraint is treated as satisfied.
module split_constraint_eval
    import split_sweep_pkg::*;
#(
    parameter int               A_W   = DEF_A_W,
    parameter int               B_W   = DEF_B_W,
    parameter int               ACC_W = DEF_ACC_W,
    parameter logic [ACC_W-1:0] SUB_K = ACC_W'(DEF_SUB_K),
    parameter logic [ACC_W-1:0] ADD_K = ACC_W'(DEF_ADD_K),
    parameter int               SHIFT = DEF_SHIFT
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    input  logic [2:0]     en,
    output logic           sat
);
    localparam int MW = max_int(A_W, B_W);

    logic [ACC_W-1:0] acc;
    logic [MW-1:0]    b_sh;
    logic [MW-1:0]    a_ext;
    logic             c1, c2, c3;

    // Wraps modulo 2^ACC_W by construction of the vector width
    assign acc   = ACC_W'(b) - SUB_K + ADD_K;
    assign b_sh  = MW'(b) >> SHIFT;
    assign a_ext = MW'(a);

    assign c1 = |acc;
    assign c2 = (a != '0);
    assign c3 = ((b_sh ^ a_ext) != '0);

    assign sat = (c1 | ~en[EN_C1]) & (c2 | ~en[EN_C2]) & (c3 | ~en[EN_C3]);
endmodule

// File: rtl/split_sweep_checker.sv
// Sweeps an inclusive A x B rectangle one candidate per clock, counting and
// optionally streaming every assignment that satisfies the enabled constraints.
module split_sweep_checker
    import split_sweep_pkg::*;
#(
    parameter int               A_W   = DEF_A_W,
    parameter int               B_W   = DEF_B_W,
    parameter int               ACC_W = DEF_ACC_W,
    parameter logic [ACC_W-1:0] SUB_K = ACC_W'(DEF_SUB_K),
    parameter logic [ACC_W-1:0] ADD_K = ACC_W'(DEF_ADD_K),
    parameter int               SHIFT = DEF_SHIFT,
    parameter int               CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  stream_en,
    input  logic [2:0]            cfg_en,
    input  logic [A_W-1:0]        a_lo,
    input  logic [A_W-1:0]        a_hi,
    input  logic [B_W-1:0]        b_lo,
    input  logic [B_W-1:0]        b_hi,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      sat_count,
    output logic                  found,
    output logic [A_W-1:0]        first_a,
    output logic [B_W-1:0]        first_b,
    split_sweep_checker_if.master sol
);
    state_e           state_q, state_d;
    logic [A_W-1:0]   a_q, a_d, a_lo_q, a_lo_d, a_hi_q, a_hi_d;
    logic [B_W-1:0]   b_q, b_d, b_hi_q, b_hi_d;
    logic [2:0]       en_q, en_d;
    logic             stream_en_q, stream_en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             found_q, found_d;
    logic [A_W-1:0]   first_a_q, first_a_d;
    logic [B_W-1:0]   first_b_q, first_b_d;
    logic             sol_valid_q, sol_valid_d;
    logic [A_W-1:0]   sol_a_q, sol_a_d;
    logic [B_W-1:0]   sol_b_q, sol_b_d;
    logic             sat, xfer, stall, done_c;

    split_constraint_eval #(
        .A_W   (A_W),
        .B_W   (B_W),
        .ACC_W (ACC_W),
        .SUB_K (SUB_K),
        .ADD_K (ADD_K),
        .SHIFT (SHIFT)
    ) u_eval (
        .a   (a_q),
        .b   (b_q),
        .en  (en_q),
        .sat (sat)
    );

    assign xfer  = sol_valid_q & sol.sol_ready;
    // Only a solution that cannot be handed over freezes the sweep
    assign stall = sat & stream_en_q & sol_valid_q & ~sol.sol_ready;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        a_lo_d      = a_lo_q;
        a_hi_d      = a_hi_q;
        b_hi_d      = b_hi_q;
        en_d        = en_q;
        stream_en_d = stream_en_q;
        cnt_d       = cnt_q;
        found_d     = found_q;
        first_a_d   = first_a_q;
        first_b_d   = first_b_q;
        sol_valid_d = sol_valid_q;
        sol_a_d     = sol_a_q;
        sol_b_d     = sol_b_q;
        done_c      = 1'b0;

        if (xfer) sol_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    a_lo_d      = a_lo;
                    a_hi_d      = a_hi;
                    b_hi_d      = b_hi;
                    en_d        = cfg_en;
                    stream_en_d = stream_en;
                    cnt_d       = '0;
                    found_d     = 1'b0;
                    a_d         = a_lo;
                    b_d         = b_lo;
                    if ((a_lo > a_hi) || (b_lo > b_hi)) state_d = FLUSH;
                    else                                state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_d     = IDLE;
                    sol_valid_d = 1'b0;
                end else if (!stall) begin
                    if (sat) begin
                        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                        if (!found_q) begin
                            found_d   = 1'b1;
                            first_a_d = a_q;
                            first_b_d = b_q;
                        end
                        if (stream_en_q) begin
                            sol_valid_d = 1'b1;
                            sol_a_d     = a_q;
                            sol_b_d     = b_q;
                        end
                    end
                    // Equality-only bounds so an all-ones hi never wraps
                    if (a_q != a_hi_q) begin
                        a_d = a_q + A_W'(1);
                    end else begin
                        a_d = a_lo_q;
                        if (b_q != b_hi_q) b_d = b_q + B_W'(1);
                        else               state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (abort) begin
                    state_d     = IDLE;
                    sol_valid_d = 1'b0;
                end else if (!sol_valid_q || sol.sol_ready) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            a_lo_q      <= '0;
            a_hi_q      <= '0;
            b_hi_q      <= '0;
            en_q        <= '0;
            stream_en_q <= 1'b0;
            cnt_q       <= '0;
            found_q     <= 1'b0;
            first_a_q   <= '0;
            first_b_q   <= '0;
            sol_valid_q <= 1'b0;
            sol_a_q     <= '0;
            sol_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            a_lo_q      <= a_lo_d;
            a_hi_q      <= a_hi_d;
            b_hi_q      <= b_hi_d;
            en_q        <= en_d;
            stream_en_q <= stream_en_d;
            cnt_q       <= cnt_d;
            found_q     <= found_d;
            first_a_q   <= first_a_d;
            first_b_q   <= first_b_d;
            sol_valid_q <= sol_valid_d;
            sol_a_q     <= sol_a_d;
            sol_b_q     <= sol_b_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = done_c & ~rst;
    assign sat_count     = cnt_q;
    assign found         = found_q;
    assign first_a       = first_a_q;
    assign first_b       = first_b_q;
    assign sol.sol_valid = sol_valid_q;
    assign sol.sol_a     = sol_a_q;
    assign sol.sol_b     = sol_b_q;
endmodule

// File: doc/split_sweep_checker.md
Name: split_sweep_checker

Overview:
- Sequential successor to the flat three-constraint checker. Instead of judging one (A, B) assignment combinationally, it sweeps a rectangular range of assignments, one candidate per clock.
- For the range it counts satisfying assignments, records the first solution, and optionally streams every solution out over a valid/ready handshake.
- Constraint widths, constants and shift are parameters; each constraint can be enabled at run time.
- It sits between the solver's test-vector controller and the BDD cross-check scoreboard.

Parameters:
- A_W, 13, width of variable A.
- B_W, 14, width of variable B.
- ACC_W, 16, width of the C1 arithmetic.
- SUB_K, 16'h39dd, constant subtracted in C1.
- ADD_K, 16'he8c3, constant added in C1.
- SHIFT, 1, right-shift applied to B in C3.
- CNT_W, 16, width of the solution counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; honoured only in IDLE.
- abort  in  1  stop the current sweep.
- stream_en  in  1  stream every solution; latched at start.
- cfg_en  in  3  constraint enables {C3,C2,C1}; latched at start.
- a_lo, a_hi  in  A_W  A range, inclusive; latched at start.
- b_lo, b_hi  in  B_W  B range, inclusive; latched at start.
- busy  out  1  high in SWEEP and FLUSH.
- done  out  1  one-cycle pulse when a sweep completes.
- sat_count  out  CNT_W  number of solutions, saturating.
- found  out  1  at least one solution seen.
- first_a  out  A_W  A of the first solution.
- first_b  out  B_W  B of the first solution.
- sol_valid  out  1  solution stream valid.
- sol_ready  in  1  solution stream ready.
- sol_a  out  A_W  A of the streamed solution.
- sol_b  out  B_W  B of the streamed solution.

Behaviour:
- Constraints, evaluated combinationally on the current candidate (a, b):
  - C1 = |((zext(b) - SUB_K + ADD_K) mod 2^ACC_W).
  - C2 = (a != 0).
  - C3 = ((b >> SHIFT) ^ zext(a)) != 0, computed at max(A_W, B_W) bits.
  - sat = AND over i of (Ci | ~cfg_en_q[i]).
  - With the defaults, C1 is always 1 for 14-bit B.
- Reset: state=IDLE; busy, done, found and sol_valid all 0; sat_count, first_a, first_b, sol_a and sol_b all 0.
- FSM state IDLE:
  - start → latch all configuration inputs; clear sat_count and found.
  - If a_lo>a_hi or b_lo>b_hi → FLUSH, otherwise → SWEEP with a=a_lo, b=b_lo.
- FSM state SWEEP:
  - Evaluate one candidate per cycle.
  - Stall (hold counters, count nothing) iff sat & stream_en_q & sol_valid & ~sol_ready.
  - When not stalled and sat:
    - increment sat_count unless it is all-ones;
    - if found==0, set found and capture first_a/first_b;
    - if stream_en_q, load sol_a/sol_b and set sol_valid.
  - When not stalled, advance:
    - if a != a_hi, a++;
    - otherwise a=a_lo and, if b != b_hi, b++;
    - if a==a_hi and b==b_hi, go to FLUSH.
  - Use equality compares only; an all-ones hi bound must not overflow.
- FSM state FLUSH: wait until sol_valid==0 (or its handshake completes this cycle), then pulse done and go to IDLE.
- Stream handshake:
  - sol_valid & sol_ready → transfer; sol_valid clears unless a new solution loads in the same cycle, in which case it stays 1 with the new data.
  - sol_a/sol_b are held stable while sol_valid & ~sol_ready.
- Latency: first candidate evaluated 1 cycle after start; an unstalled sweep of N candidates gives done at cycle N+1 after start.
- abort in SWEEP or FLUSH → IDLE next cycle; sol_valid cleared; no done pulse; count/found/first keep their partial values.
- Simultaneous start and abort in IDLE: abort wins, start is ignored.
- start while busy: ignored.
- rst overrides everything at any time.

Decomposition:
- Package split_sweep_pkg holds:
  - the state enum (IDLE, SWEEP, FLUSH);
  - default constant localparams;
  - the cfg_en bit-index constants.
- One sub-module, split_constraint_eval: purely combinational, parametrised by A_W, B_W, ACC_W, SUB_K, ADD_K and SHIFT; inputs (a, b, en); output sat.
- FSM, counters and stream register stay in the top.

Test Plan:
- Count mode, defaults, A 0..3, B 0..1, cfg_en=3'b111:
  - sat_count=6, found=1, first=(1,0);
  - done at cycle 9 after start; sol_valid stays 0.
- Stream mode, same range, sol_ready held 0 for 10 cycles then 1:
  - sweep stalls on the second solution;
  - stream order (1,0),(2,0),(3,0),(1,1),(2,1),(3,1);
  - sol_a/sol_b stable while stalled; done only after the last transfer.
- A 5..5, B 10..11:
  - C3 fails both candidates → sat_count=0, found=0, done pulses.
  - Repeat with cfg_en=3'b011 → sat_count=2, first=(5,10).
- Empty range a_lo=4, a_hi=3: busy for 1 cycle, done pulses, sat_count=0.
- CNT_W=3, A 1..15, B 0..0: 15 solutions → sat_count saturates at 7.
- Mid-sweep events:
  - abort while SWEEP → IDLE next cycle, sol_valid=0, no done.
  - rst mid-sweep → all outputs at reset values.
  - start while busy → ignored.
